fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction prefetch queue between the fetch unit and the decode stage. Each cycle it captures one {PC, instruction} pair from fetch. It holds the pair in a small first-word-fall-through FIFO and presents the oldest entry to decode under a valid/ready handshake. Back-pressure is returned to fetch as `in_ready` (fetch stall = `~in_ready`). A redirect (`flush`) discards every buffered entry in one cycle.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥ 2
- `NOP_INSTR`, 32'h00000013, value driven on `out_instr` when the buffer is empty (addi x0,x0,0)

- `clock`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `in_valid`  input  1  fetch presents a valid pair this cycle
- `in_pc`  input  32  PC of the fetched instruction
- `in_instr`  input  32  fetched instruction word
- `in_ready`  output  1  buffer can accept a push this cycle
- `out_valid`  output  1  head entry is valid
- `out_pc`  output  32  PC of the head entry
- `out_instr`  output  32  instruction of the head entry
- `out_ready`  input  1  decode consumes the head entry this cycle
- `flush`  input  1  discard all entries; same-cycle redirect as fetch `pc_src`
- `count`  output  $clog2(DEPTH)+1  number of valid entries

## Operation
- Storage: `DEPTH` × 64-bit entries ({pc, instr}), write pointer `wp`, read pointer `rp`, occupancy `count`. All are registered.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally modulo `DEPTH`.
- `push = in_valid & in_ready`. `pop = out_valid & out_ready`.
- `in_ready = (count != DEPTH)`. It depends only on registered state, with no combinational path from `out_ready`. A full buffer refuses a push even in a cycle where it pops.
- `out_valid = (count != 0)`.
- When `out_valid` is 1: `out_pc`/`out_instr` = entry[`rp`].
- When the buffer is empty: `out_pc` = 0 and `out_instr` = `NOP_INSTR`.
- On push: entry[`wp`] ← {`in_pc`, `in_instr`}; `wp` ← `wp`+1.
- On pop: `rp` ← `rp`+1.
- Count update: push only → `count`+1; pop only → `count`−1; push and pop together → `count` unchanged.
- `flush` has priority over everything else. On flush: `wp`, `rp` and `count` go to 0, and any same-cycle push or pop is ignored. Storage contents need not be cleared.
- Control is a two-state view derived from `count`:
  - EMPTY (`count` == 0)
  - NONEMPTY
  - FULL is the NONEMPTY sub-case `count` == `DEPTH`.
- `in_valid` while `in_ready` = 0 is not an error. The pair is simply not taken; fetch holds its PC via stall.
- `out_ready` while `out_valid` = 0 is ignored. No pointer moves and `count` does not underflow.

## Timing
- Reset (asynchronous, immediate):
  - `wp` = `rp` = `count` = 0
  - `in_ready` = 1, `out_valid` = 0
  - `out_pc` = 0, `out_instr` = `NOP_INSTR`
- A reset asserted mid-operation discards all entries exactly like `flush`, but asynchronously.
- Latency: a pair pushed at edge N appears on `out_*` after edge N (one cycle). There is no same-cycle bypass from `in_*` to `out_*`.
- Outputs are combinational from registered state only (mux on `rp`). `in_ready`/`out_valid` settle before the next edge independent of `out_ready`/`in_valid`.
- Flush at edge N: in the cycle after edge N, `out_valid` = 0, `in_ready` = 1 and `count` = 0. The first post-redirect pair from fetch can be pushed in that cycle.
- Throughput: one push and one pop per cycle sustained when 0 < `count` < `DEPTH`.
- Wrap-around: after `DEPTH` pushes, `wp` returns to 0. Ordering stays strictly FIFO across the wrap.

## Test plan
- Reset then idle → `in_ready`=1, `out_valid`=0, `count`=0, `out_instr`=0x00000013, `out_pc`=0.
- Push PC 0x0/0x4/0x8/0xC (instr 0xA0..0xA3) with `out_ready`=0 → `count`=4, `in_ready`=0.
  - A fifth push with PC 0x10 is refused.
  - Then `out_ready`=1 for 4 cycles → `out_pc` sequence is 0x0, 0x4, 0x8, 0xC; then `out_valid`=0.
- Continuous streaming with `in_valid`=`out_ready`=1 for 10 cycles from PC 0x100 → `count` stays 1 after the first cycle.
  - `out_pc` follows 0x100, 0x104, … one cycle behind the input.
  - Pointers wrap past `DEPTH` with order preserved.
- Fill with 3 entries, then assert `flush` together with `in_valid` (PC 0x200) and `out_ready` → next cycle `count`=0, `out_valid`=0, and PC 0x200 is not stored.
  - Next push (PC 0x400) appears at `out_pc` one cycle later.
- At `count`=4, assert `out_ready`=1 and `in_valid`=1 → pop occurs, push is refused (`in_ready` was 0), `count`=3.
  - Next cycle `in_ready`=1 and the push is accepted.
- Assert `reset` asynchronously mid-cycle with `count`=2 → outputs return to reset values before the next clock edge.
  - After release, the first push appears at the output one cycle later.

Source files
------------

// File: rtl/fetch_buffer_if.sv
// Fetch/decode handshake bundle for the instruction prefetch queue.
// master = fetch+decode side, slave = the buffer itself.
interface fetch_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic          flush;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_pc, in_instr,
    output out_ready, flush,
    input  in_ready, out_valid,
    input  out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr,
    input  out_ready, flush,
    output in_ready, out_valid,
    output out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_buffer.sv
// First-word-fall-through prefetch queue between fetch and decode.
// Flush/reset drop all entries; head is muxed from registered state.
module fetch_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic           clock,
  input logic           reset,
  fetch_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {
    S_EMPTY,
    S_NONEMPTY
  } state_t;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;

  state_t        w_state;
  logic          w_full;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_push;
  logic          w_pop;
  logic [63:0]   w_head;

  always_comb begin
    w_state = S_EMPTY;
    if (r_count != '0) w_state = S_NONEMPTY;
  end

  assign w_full      = (r_count == FULL_CNT);
  assign w_in_ready  = !w_full;
  assign w_out_valid = (w_state == S_NONEMPTY);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;
  assign w_head      = r_mem[r_rp];

  always_ff @(posedge clock) begin
    if (w_push && !bus.flush)
      r_mem[r_wp] <= {bus.in_pc, bus.in_instr};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.count     = r_count;

  // Empty buffer feeds decode a harmless NOP rather than stale data.
  always_comb begin
    bus.out_pc    = 32'h0;
    bus.out_instr = NOP_INSTR;
    if (w_out_valid) begin
      bus.out_pc    = w_head[63:32];
      bus.out_instr = w_head[31:0];
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer.
// Inputs change 1ns after the rising edge.
module tb_fetch_buffer;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  fetch_buffer_if #(.DEPTH(DEPTH)) fb ();

  fetch_buffer #(
    .DEPTH    (DEPTH),
    .NOP_INSTR(NOP)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (fb.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fb.in_valid  = 1'b0;
    fb.in_pc     = 32'h0;
    fb.in_instr  = 32'h0;
    fb.out_ready = 1'b0;
    fb.flush     = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc,
                      input logic [31:0] ins);
    fb.in_valid = 1'b1;
    fb.in_pc    = pc;
    fb.in_instr = ins;
    step();
    fb.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    n_chk++;
    if (fb.in_ready !== 1'b1)
      $display("FAIL rst_in_ready got %b want 1", fb.in_ready);
    else n_pass++;
    n_chk++;
    if (fb.out_valid !== 1'b0)
      $display("FAIL rst_out_valid got %b want 0", fb.out_valid);
    else n_pass++;
    n_chk++;
    if (fb.count !== 3'd0)
      $display("FAIL rst_count got %0d want 0", fb.count);
    else n_pass++;
    n_chk++;
    if (fb.out_instr !== NOP)
      $display("FAIL rst_instr got %h want %h", fb.out_instr, NOP);
    else n_pass++;
    n_chk++;
    if (fb.out_pc !== 32'h0)
      $display("FAIL rst_pc got %h want 0", fb.out_pc);
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    idle();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (fb.in_ready !== 1'b1)
        $display("FAIL fill_ready[%0d] got %b want 1", i, fb.in_ready);
      else n_pass++;
      push(32'(4 * i), 32'hA0 + 32'(i));
    end
    n_chk++;
    if (fb.count !== 3'd4)
      $display("FAIL fill_count got %0d want 4", fb.count);
    else n_pass++;
    n_chk++;
    if (fb.in_ready !== 1'b0)
      $display("FAIL full_ready got %b want 0", fb.in_ready);
    else n_pass++;
    push(32'h10, 32'hA4);
    n_chk++;
    if (fb.count !== 3'd4)
      $display("FAIL refuse_count got %0d want 4", fb.count);
    else n_pass++;
    fb.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (fb.out_valid !== 1'b1 || fb.out_pc !== 32'(4 * i) ||
          fb.out_instr !== 32'hA0 + 32'(i))
        $display("FAIL drain[%0d] got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                 i, fb.out_valid, fb.out_pc, fb.out_instr,
                 32'(4 * i), 32'hA0 + 32'(i));
      else n_pass++;
      step();
    end
    n_chk++;
    if (fb.out_valid !== 1'b0 || fb.out_instr !== NOP || fb.count !== 3'd0)
      $display("FAIL drained got v=%b ins=%h cnt=%0d want v=0 ins=%h cnt=0",
               fb.out_valid, fb.out_instr, fb.count, NOP);
    else n_pass++;
    // extra pop request on empty must not underflow
    step();
    n_chk++;
    if (fb.count !== 3'd0 || fb.in_ready !== 1'b1)
      $display("FAIL underflow got cnt=%0d rdy=%b want cnt=0 rdy=1",
               fb.count, fb.in_ready);
    else n_pass++;
    idle();
  endtask

  task automatic test_back_to_back();
    idle();
    fb.out_ready = 1'b1;
    fb.in_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      fb.in_pc    = 32'h100 + 32'(4 * k);
      fb.in_instr = 32'hB0 + 32'(k);
      if (k > 0) begin
        n_chk++;
        if (fb.count !== 3'd1 || fb.out_pc !== 32'h100 + 32'(4 * (k - 1)) ||
            fb.out_instr !== 32'hB0 + 32'(k - 1))
          $display("FAIL stream[%0d] got cnt=%0d pc=%h ins=%h want cnt=1 pc=%h ins=%h",
                   k, fb.count, fb.out_pc, fb.out_instr,
                   32'h100 + 32'(4 * (k - 1)), 32'hB0 + 32'(k - 1));
        else n_pass++;
      end
      step();
    end
    fb.in_valid = 1'b0;
    n_chk++;
    if (fb.out_pc !== 32'h124 || fb.count !== 3'd1)
      $display("FAIL stream_last got pc=%h cnt=%0d want pc=124 cnt=1",
               fb.out_pc, fb.count);
    else n_pass++;
    step();
    n_chk++;
    if (fb.count !== 3'd0)
      $display("FAIL stream_end got cnt=%0d want 0", fb.count);
    else n_pass++;
    idle();
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 3; i++)
      push(32'h300 + 32'(4 * i), 32'hC0 + 32'(i));
    fb.flush     = 1'b1;
    fb.in_valid  = 1'b1;
    fb.in_pc     = 32'h200;
    fb.in_instr  = 32'hDEAD;
    fb.out_ready = 1'b1;
    step();
    idle();
    n_chk++;
    if (fb.count !== 3'd0 || fb.out_valid !== 1'b0 || fb.in_ready !== 1'b1)
      $display("FAIL flush got cnt=%0d v=%b rdy=%b want cnt=0 v=0 rdy=1",
               fb.count, fb.out_valid, fb.in_ready);
    else n_pass++;
    push(32'h400, 32'hE0);
    n_chk++;
    if (fb.out_valid !== 1'b1 || fb.out_pc !== 32'h400 ||
        fb.out_instr !== 32'hE0 || fb.count !== 3'd1)
      $display("FAIL post_flush got v=%b pc=%h ins=%h cnt=%0d want v=1 pc=400 ins=e0 cnt=1",
               fb.out_valid, fb.out_pc, fb.out_instr, fb.count);
    else n_pass++;
    fb.out_ready = 1'b1;
    step();
    fb.out_ready = 1'b0;
    n_chk++;
    if (fb.count !== 3'd0)
      $display("FAIL flush_nostore got cnt=%0d want 0", fb.count);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_pc [4];
    idle();
    for (int i = 0; i < 4; i++)
      push(32'h500 + 32'(4 * i), 32'hF0 + 32'(i));
    fb.in_valid  = 1'b1;
    fb.in_pc     = 32'h600;
    fb.in_instr  = 32'hF9;
    fb.out_ready = 1'b1;
    n_chk++;
    if (fb.in_ready !== 1'b0)
      $display("FAIL fp_ready got %b want 0", fb.in_ready);
    else n_pass++;
    step();
    n_chk++;
    if (fb.count !== 3'd3 || fb.in_ready !== 1'b1 || fb.out_pc !== 32'h504)
      $display("FAIL fp_pop got cnt=%0d rdy=%b pc=%h want cnt=3 rdy=1 pc=504",
               fb.count, fb.in_ready, fb.out_pc);
    else n_pass++;
    fb.out_ready = 1'b0;
    step();
    fb.in_valid = 1'b0;
    n_chk++;
    if (fb.count !== 3'd4)
      $display("FAIL fp_push got cnt=%0d want 4", fb.count);
    else n_pass++;
    exp_pc[0] = 32'h504;
    exp_pc[1] = 32'h508;
    exp_pc[2] = 32'h50C;
    exp_pc[3] = 32'h600;
    fb.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (fb.out_pc !== exp_pc[i])
        $display("FAIL fp_order[%0d] got %h want %h", i, fb.out_pc, exp_pc[i]);
      else n_pass++;
      step();
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    push(32'h700, 32'h70);
    push(32'h704, 32'h71);
    n_chk++;
    if (fb.count !== 3'd2)
      $display("FAIL ar_pre got cnt=%0d want 2", fb.count);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (fb.count !== 3'd0 || fb.out_valid !== 1'b0 || fb.in_ready !== 1'b1 ||
        fb.out_pc !== 32'h0 || fb.out_instr !== NOP)
      $display("FAIL ar_now got cnt=%0d v=%b rdy=%b pc=%h ins=%h want 0/0/1/0/%h",
               fb.count, fb.out_valid, fb.in_ready, fb.out_pc, fb.out_instr, NOP);
    else n_pass++;
    #1;
    rst = 1'b0;
    step();
    push(32'h800, 32'h80);
    n_chk++;
    if (fb.out_valid !== 1'b1 || fb.out_pc !== 32'h800 ||
        fb.out_instr !== 32'h80 || fb.count !== 3'd1)
      $display("FAIL ar_post got v=%b pc=%h ins=%h cnt=%0d want v=1 pc=800 ins=80 cnt=1",
               fb.out_valid, fb.out_pc, fb.out_instr, fb.count);
    else n_pass++;
  endtask

  initial begin
    idle();
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_full_pop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
